cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Miss-refill stage directly downstream of the 4-way cache (1 KB, 16 B lines, 4 words/line, 16 sets).
- On a read miss it fetches the 4 words of the missing line from the memory side with a req/ack word handshake and assembles a 128-bit line.
- It then presents the line to the cache's line-write port for one cycle.
- One outstanding miss at a time; the cache stalls on busy_o.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, memory word width
- WORDS_PER_LINE, 4, words per cache line; the line is DATA_W*WORDS_PER_LINE bits

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset (low = reset)
- miss_i  input  1  cache read miss; sampled only in IDLE
- miss_addr_i  input  ADDR_W  byte address of the missing access
- busy_o  output  1  refill in progress; cache must hold the request
- mem_req_o  output  1  memory word request
- mem_addr_o  output  ADDR_W  word-aligned address of the requested word
- mem_ack_i  input  1  memory returns mem_rdata_i this cycle
- mem_rdata_i  input  DATA_W  returned word
- refill_wen_o  output  1  one-cycle line write strobe to the cache
- refill_addr_o  output  ADDR_W  line-aligned address (offset bits zero)
- refill_line_o  output  DATA_W*WORDS_PER_LINE  assembled line
- crit_valid_o  output  1  critical-word forward strobe (optional feature only)
- crit_data_o  output  DATA_W  critical word

Behaviour:
- Reset: async assert, sync release. All outputs are 0, state is IDLE, line buffer is 0 and counters are 0.
- Reset mid-refill aborts the refill: no refill_wen_o is issued and partial data is discarded.
- States: IDLE, FETCH, FILL.
- IDLE:
  - miss_i=1 at a clock edge latches the line address and the start word index (0, or miss_addr_i[3:2] with the optional feature), then moves to FETCH.
  - busy_o=0 and mem_req_o=0.
  - mem_ack_i is ignored.
- FETCH:
  - busy_o=1 and mem_req_o=1.
  - mem_addr_o = {line_addr[31:4], widx[1:0], 2'b00}, held stable until acked.
  - On each mem_ack_i the word is written into line bits [32*widx+31 : 32*widx].
  - widx increments mod 4 (wraps 3->0) and the done count increments.
  - req stays high for back-to-back words.
  - When the 4th ack is taken, the next state is FILL and mem_req_o drops the following cycle.
- FILL:
  - refill_wen_o=1 for exactly one cycle, with refill_addr_o and refill_line_o valid that same cycle; busy_o=1.
  - Next state is IDLE.
  - refill_line_o and refill_addr_o hold their values afterwards until the next FILL.
- miss_i is ignored in FETCH and FILL. A miss asserted in the first IDLE cycle after FILL is accepted.
- Latency: miss_i sampled at edge 0; with ack every cycle, mem_req_o is high cycles 1-4 and refill_wen_o is high cycle 5.
- Acks with gaps only stretch FETCH.
- The line is always exactly 4 words: no partial line write, no duplicate word index.

Optional Feature:
- Macro: CACHE_REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Fetch starts at widx = miss_addr_i[3:2] and wraps mod 4.
  - On the first ack, crit_valid_o=1 for one cycle the cycle after the ack, with crit_data_o = that word.
- Undefined:
  - Fetch order is always 0,1,2,3.
  - crit_valid_o and crit_data_o are tied 0.
- refill_line_o is identical in both builds.

Decomposition:
- Shared package cache_pkg holds:
  - OFFSET_W=4, INDEX_W=4, TAG_W=24, WORDS_PER_LINE=4, LINE_W=128
  - enum refill_state_e {IDLE, FETCH, FILL}
  - helper function line_base(addr), which zeroes the offset bits
- One sub-module, refill_line_buf: a 128-bit register with a 2-bit word-select write port, a clear input and async active-low reset.

Test Plan:
- Ack every cycle: miss_addr_i=0x0000_1234, mem returns 0xA0,0xA1,0xA2,0xA3.
  - mem_addr_o = 0x1230, 0x1234, 0x1238, 0x123C.
  - refill_wen_o in cycle 5, refill_addr_o=0x1230, refill_line_o=0x..A3_..A2_..A1_..A0.
- Gapped acks: acks only every 3rd cycle.
  - mem_addr_o is held stable until each ack.
  - refill_wen_o comes exactly one cycle after the 4th ack, with the same line contents as the ack-every-cycle case.
- miss_i held high through the whole refill and a second miss_addr_i=0x2000 pulsed during FETCH.
  - Only one refill occurs for the first address; the second is accepted only in IDLE after FILL.
- rst driven low after 2 acks, then released.
  - All outputs go 0 immediately and no refill_wen_o is issued.
  - A new miss to 0x40 refills cleanly.
- With CACHE_REFILL_CRITICAL_WORD_FIRST_EN, miss_addr_i=0x0000_00F8.
  - mem_addr_o order is 0xF8, 0xFC, 0xF0, 0xF4 (wrap).
  - crit_valid_o pulses with the first returned word.
  - refill_line_o has words in natural positions.
- Stray mem_ack_i=1 while IDLE: no state change and no refill_wen_o.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared geometry, refill states and address helper for the cache refill path
package cache_pkg;

    localparam int OFFSET_W       = 4;
    localparam int INDEX_W        = 4;
    localparam int TAG_W          = 24;
    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_W         = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } refill_state_e;

    // Tag and index survive; the byte offset within the line is cleared.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        line_base = {addr[OFFSET_W+INDEX_W+TAG_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/refill_line_buf.sv
// rtl/refill_line_buf.sv - line assembly register with word-select write port and clear
module refill_line_buf
    import cache_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               wen,
    input  logic [1:0]                         wsel,
    input  logic [LINE_W/WORDS_PER_LINE-1:0]   wdata,
    output logic [LINE_W-1:0]                  line
);

    localparam int WORD_W = LINE_W / WORDS_PER_LINE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else if (wen) begin
            line[WORD_W*int'(wsel) +: WORD_W] <= wdata;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache miss refill: 4-word fetch, line assembly, one-cycle line write
// Optional critical-word-first ordering and forwarding: CACHE_REFILL_CRITICAL_WORD_FIRST_EN
module cache_refill_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_i,
    input  logic [ADDR_W-1:0]                  miss_addr_i,
    output logic                               busy_o,
    output logic                               mem_req_o,
    output logic [ADDR_W-1:0]                  mem_addr_o,
    input  logic                               mem_ack_i,
    input  logic [DATA_W-1:0]                  mem_rdata_i,
    output logic                               refill_wen_o,
    output logic [ADDR_W-1:0]                  refill_addr_o,
    output logic [DATA_W*WORDS_PER_LINE-1:0]   refill_line_o,
    output logic                               crit_valid_o,
    output logic [DATA_W-1:0]                  crit_data_o
);

    import cache_pkg::refill_state_e;
    import cache_pkg::IDLE;
    import cache_pkg::FETCH;
    import cache_pkg::FILL;
    import cache_pkg::OFFSET_W;
    import cache_pkg::line_base;

    localparam int WIDX_W    = $clog2(WORDS_PER_LINE);
    localparam int LINE_BITS = DATA_W * WORDS_PER_LINE;

    refill_state_e         state_q, state_d;
    logic [ADDR_W-1:0]     line_addr_q, held_addr_q;
    logic [WIDX_W-1:0]     widx_q, start_idx;
    logic [WIDX_W:0]       done_q;
    logic [LINE_BITS-1:0]  buf_line, held_line_q;
    logic                  accept, take, last;

    assign accept = (state_q == IDLE) && miss_i;
    assign take   = (state_q == FETCH) && mem_ack_i;
    assign last   = take && (done_q == (WIDX_W+1)'(WORDS_PER_LINE-1));

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    assign start_idx = miss_addr_i[2 +: WIDX_W];
`else
    assign start_idx = '0;
`endif

    always_comb begin
        state_d       = state_q;
        busy_o        = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        refill_wen_o  = 1'b0;
        refill_addr_o = held_addr_q;
        refill_line_o = held_line_q;
        case (state_q)
            IDLE: begin
                if (miss_i) state_d = FETCH;
            end
            FETCH: begin
                busy_o     = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {line_addr_q[ADDR_W-1:OFFSET_W], widx_q, 2'b00};
                if (last) state_d = FILL;
            end
            FILL: begin
                busy_o        = 1'b1;
                refill_wen_o  = 1'b1;
                refill_addr_o = line_addr_q;
                refill_line_o = buf_line;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            widx_q      <= '0;
            done_q      <= '0;
            held_addr_q <= '0;
            held_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                line_addr_q <= line_base(miss_addr_i);
                widx_q      <= start_idx;
                done_q      <= '0;
            end else if (take) begin
                widx_q <= widx_q + WIDX_W'(1);
                done_q <= done_q + (WIDX_W+1)'(1);
            end
            // Outputs keep showing the last written line between refills.
            if (state_q == FILL) begin
                held_addr_q <= line_addr_q;
                held_line_q <= buf_line;
            end
        end
    end

    refill_line_buf u_line_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .wen   (take),
        .wsel  (widx_q),
        .wdata (mem_rdata_i),
        .line  (buf_line)
    );

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic              crit_valid_q;
    logic [DATA_W-1:0] crit_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= take && (done_q == '0);
            if (take && (done_q == '0)) crit_data_q <= mem_rdata_i;
        end
    end

    assign crit_valid_o = crit_valid_q;
    assign crit_data_o  = crit_data_q;
`else
    assign crit_valid_o = 1'b0;
    assign crit_data_o  = '0;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - randomized self-checking bench for cache_refill_ctrl
module tb_cache_refill_ctrl;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_i;
    logic [31:0]  miss_addr_i;
    logic         busy_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_ack_i;
    logic [31:0]  mem_rdata_i;
    logic         refill_wen_o;
    logic [31:0]  refill_addr_o;
    logic [127:0] refill_line_o;
    logic         crit_valid_o;
    logic [31:0]  crit_data_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0]  exp_held_addr = '0;
    logic [127:0] exp_held_line = '0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .miss_i        (miss_i),
        .miss_addr_i   (miss_addr_i),
        .busy_o        (busy_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .refill_wen_o  (refill_wen_o),
        .refill_addr_o (refill_addr_o),
        .refill_line_o (refill_line_o),
        .crit_valid_o  (crit_valid_o),
        .crit_data_o   (crit_data_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, busy_o, 1'b0);
        check_eq({tag, "_req"}, mem_req_o, 1'b0);
        check_eq({tag, "_wen"}, refill_wen_o, 1'b0);
        check_eq({tag, "_raddr"}, refill_addr_o, exp_held_addr);
        check_eq({tag, "_rline"}, refill_line_o, exp_held_line);
    endtask

    // One complete refill. Called at a negedge with the DUT in IDLE; returns at the
    // negedge of the first IDLE cycle after FILL. gap: 0 every cycle, N>0 ack every
    // (N+1)th cycle, <0 random. hold keeps miss_i high and moves miss_addr_i to alt mid-fetch.
    task automatic run_refill(input logic [31:0] addr, input logic [127:0] line,
                              input int gap, input bit hold, input logic [31:0] alt);
        int  start, k, cyc, idx;
        bit  do_ack, prev_first;
        start = CRIT_EN ? int'(addr[3:2]) : 0;
        miss_i = 1'b1;
        miss_addr_i = addr;
        @(negedge clk);
        if (!hold) miss_i = 1'b0;
        k = 0;
        cyc = 0;
        prev_first = 1'b0;
        while (k < 4 && cyc < 100) begin
            check_eq("fetch_busy", busy_o, 1'b1);
            check_eq("fetch_req", mem_req_o, 1'b1);
            check_eq("fetch_maddr", mem_addr_o, {addr[31:4], 2'((start + k) % 4), 2'b00});
            check_eq("fetch_wen", refill_wen_o, 1'b0);
            check_eq("crit_valid", crit_valid_o, CRIT_EN && prev_first);
            if (CRIT_EN && prev_first)
                check_eq("crit_data", crit_data_o, line[32*start +: 32]);
            if (gap == 0)      do_ack = 1'b1;
            else if (gap > 0)  do_ack = (cyc % (gap + 1)) == gap;
            else               do_ack = $urandom_range(0, 2) != 0;
            idx = (start + k) % 4;
            mem_ack_i = do_ack;
            mem_rdata_i = do_ack ? line[32*idx +: 32] : $urandom;
            prev_first = do_ack && (k == 0);
            if (do_ack) k++;
            if (hold && cyc == 1) miss_addr_i = alt;
            cyc++;
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        check_eq("fetch_timeout", k, 4);
        check_eq("fill_wen", refill_wen_o, 1'b1);
        check_eq("fill_busy", busy_o, 1'b1);
        check_eq("fill_req", mem_req_o, 1'b0);
        check_eq("fill_addr", refill_addr_o, {addr[31:4], 4'h0});
        check_eq("fill_line", refill_line_o, line);
        check_eq("fill_crit", crit_valid_o, 1'b0);
        exp_held_addr = {addr[31:4], 4'h0};
        exp_held_line = line;
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        check_idle("post_fill");
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] line_a, l2, l3;
        rst = 1'b0;
        miss_i = 1'b0;
        miss_addr_i = '0;
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check_eq("reset_maddr", mem_addr_o, 32'h0);
        check_eq("reset_crit", crit_valid_o, 1'b0);
        check_eq("reset_critd", crit_data_o, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // stray acks in IDLE
        mem_ack_i = 1'b1;
        repeat (3) begin
            mem_rdata_i = $urandom;
            @(negedge clk);
            check_idle("stray_ack");
        end
        mem_ack_i = 1'b0;

        line_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        run_refill(32'h0000_1234, line_a, 0, 1'b0, '0);
        run_refill(32'h0000_1234, line_a, 2, 1'b0, '0);

        // miss held high, address changed mid-fetch; second miss accepted right after FILL
        l2 = rand_line();
        l3 = rand_line();
        run_refill(32'h0000_1234, l2, 0, 1'b1, 32'h0000_2000);
        run_refill(32'h0000_2000, l3, 0, 1'b0, '0);

        // reset mid-refill after two acks
        miss_i = 1'b1;
        miss_addr_i = 32'h0000_1234;
        @(negedge clk);
        miss_i = 1'b0;
        mem_ack_i = 1'b1;
        repeat (2) begin
            mem_rdata_i = $urandom;
            @(negedge clk);
        end
        mem_ack_i = 1'b0;
        rst = 1'b0;
        #1;
        exp_held_addr = '0;
        exp_held_line = '0;
        check_idle("async_rst");
        check_eq("async_rst_maddr", mem_addr_o, 32'h0);
        check_eq("async_rst_crit", crit_valid_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("after_rst");
        end
        run_refill(32'h0000_0040, rand_line(), 0, 1'b0, '0);

        // wrapping fetch order when critical-word-first is built in
        run_refill(32'h0000_00F8, rand_line(), 0, 1'b0, '0);
        run_refill(32'h0000_00F8, rand_line(), -1, 1'b0, '0);

        for (int i = 0; i < 10; i++) begin
            run_refill($urandom, rand_line(), -1, 1'b0, '0);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check_idle("gap_idle");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
